// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: runs multi-cycle mult/div and owns the
// architectural HI/LO registers. It also raises stall for the hazard unit.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] e_v1,
  input  logic [31:0] e_v2,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [31:0]      pend_hi, pend_lo, pend_hi_nxt, pend_lo_nxt;

  // Shared multiplier: sign-extend operands only for signed mult.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, mul_p;

  always_comb begin
    mul_signed = (md_op == OP_MULT);
    mul_a      = {{32{mul_signed & e_v1[31]}}, e_v1};
    mul_b      = {{32{mul_signed & e_v2[31]}}, e_v2};
    mul_p      = mul_a * mul_b;
  end

  // Shared divider on magnitudes; signs restored afterwards so that
  // 0x80000000 / -1 wraps to 0x80000000 without overflow trouble.
  logic        div_signed, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, div_q, div_r;

  always_comb begin
    div_signed = (md_op == OP_DIV);
    a_neg      = div_signed & e_v1[31];
    b_neg      = div_signed & e_v2[31];
    a_mag      = a_neg ? (~e_v1 + 32'd1) : e_v1;
    b_mag      = b_neg ? (~e_v2 + 32'd1) : e_v2;
    q_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    r_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    div_q      = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    div_r      = a_neg ? (~r_mag + 32'd1) : r_mag;
  end

  assign stall = d_md_use & (busy | (start & (md_op <= OP_DIVU)));

  // Next-state and register updates.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    busy_nxt    = busy;
    hi_nxt      = hi;
    lo_nxt      = lo;
    pend_hi_nxt = pend_hi;
    pend_lo_nxt = pend_lo;

    case (state)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            OP_MULT, OP_MULTU: begin
              pend_hi_nxt = mul_p[63:32];
              pend_lo_nxt = mul_p[31:0];
              cnt_nxt     = MULT_LOAD;
              busy_nxt    = 1'b1;
              state_nxt   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              // Divide by zero commits the current HI/LO, i.e. no change.
              if (e_v2 == 32'd0) begin
                pend_hi_nxt = hi;
                pend_lo_nxt = lo;
              end else begin
                pend_hi_nxt = div_r;
                pend_lo_nxt = div_q;
              end
              cnt_nxt   = DIV_LOAD;
              busy_nxt  = 1'b1;
              state_nxt = S_BUSY;
            end
            OP_MTHI: hi_nxt = e_v1;
            OP_MTLO: lo_nxt = e_v1;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        if (cnt == CNT_ONE) begin
          hi_nxt    = pend_hi;
          lo_nxt    = pend_lo;
          cnt_nxt   = '0;
          busy_nxt  = 1'b0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      busy    <= busy_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
      pend_hi <= pend_hi_nxt;
      pend_lo <= pend_lo_nxt;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed literal cases plus randomized traffic
// compared every cycle against a cycle-count/arithmetic model.
module tb_e_mdu;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset, start, d_md_use;
  logic [2:0]  md_op;
  logic [31:0] e_v1, e_v2;
  logic        busy, stall;
  logic [31:0] hi, lo;

  e_mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .e_v1     (e_v1),
    .e_v2     (e_v2),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op finishes at an absolute edge number; busy until then.
  int          edge_n    = 0;
  int          done_edge = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  bit          p_valid   = 1'b0;
  bit          m_busy    = 1'b0;
  bit          checking  = 1'b0;

  task automatic model_issue();
    logic [63:0] r64;
    longint      q, r;
    case (md_op)
      3'd0: begin
        r64 = longint'(int'(e_v1)) * longint'(int'(e_v2));
        p_hi = r64[63:32]; p_lo = r64[31:0]; p_valid = 1'b1;
        done_edge = edge_n + MULT_N;
      end
      3'd1: begin
        r64 = {32'd0, e_v1} * {32'd0, e_v2};
        p_hi = r64[63:32]; p_lo = r64[31:0]; p_valid = 1'b1;
        done_edge = edge_n + MULT_N;
      end
      3'd2: begin
        if (e_v2 != 32'd0) begin
          q = longint'(int'(e_v1)) / longint'(int'(e_v2));
          r = longint'(int'(e_v1)) % longint'(int'(e_v2));
          p_lo = q[31:0]; p_hi = r[31:0]; p_valid = 1'b1;
        end else begin
          p_valid = 1'b0;
        end
        done_edge = edge_n + DIV_N;
      end
      3'd3: begin
        if (e_v2 != 32'd0) begin
          p_lo = e_v1 / e_v2; p_hi = e_v1 % e_v2; p_valid = 1'b1;
        end else begin
          p_valid = 1'b0;
        end
        done_edge = edge_n + DIV_N;
      end
      3'd4: m_hi = e_v1;
      3'd5: m_lo = e_v1;
      default: ;
    endcase
  endtask

  always @(posedge clk) begin
    edge_n++;
    if (reset) begin
      m_hi = 32'd0; m_lo = 32'd0; p_valid = 1'b0; done_edge = edge_n;
    end else if (edge_n == done_edge) begin
      if (p_valid) begin
        m_hi = p_hi; m_lo = p_lo; p_valid = 1'b0;
      end
    end else if (edge_n > done_edge && start) begin
      model_issue();
    end
    m_busy = (edge_n < done_edge);
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      chk("stall", 32'(stall), 32'(d_md_use & (m_busy | (start & (md_op <= 3'd3)))));
      chk("start_while_busy", 32'(start & m_busy), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; md_op = op; e_v1 = a; e_v2 = b;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h0000_0001;
      4: return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; e_v1 = 32'd0; e_v2 = 32'd0; d_md_use = 1'b0;
    tick(); tick();
    reset = 1'b0; checking = 1'b1; d_md_use = 1'b1;
    repeat (4) tick();
    chk("idle_hi", hi, 32'd0);
    chk("idle_lo", lo, 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);

    // mult -2 * 3
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_busy_first", 32'(busy), 32'd1);
    repeat (MULT_N - 1) tick();
    chk("mult_busy_last", 32'(busy), 32'd1);
    chk("mult_stall", 32'(stall), 32'd1);
    tick();
    chk("mult_busy_done", 32'(busy), 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    issue(3'd3, 32'd17, 32'd5);
    repeat (DIV_N) tick();
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd2);

    issue(3'd2, 32'hFFFF_FFEF, 32'd5);
    repeat (DIV_N) tick();
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFE);

    issue(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_hi", hi, 32'h1234_5678);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(3'd5, 32'h9ABC_DEF0, 32'd0);
    chk("mtlo_lo", lo, 32'h9ABC_DEF0);
    chk("mtlo_hi", hi, 32'h1234_5678);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (DIV_N) tick();
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'd0);

    // divide by zero keeps HI/LO, then back-to-back multu
    issue(3'd4, 32'h0000_AAAA, 32'd0);
    issue(3'd5, 32'h0000_5555, 32'd0);
    issue(3'd2, 32'h0000_1234, 32'd0);
    repeat (DIV_N) tick();
    chk("div0_busy", 32'(busy), 32'd0);
    chk("div0_hi", hi, 32'h0000_AAAA);
    chk("div0_lo", lo, 32'h0000_5555);
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_busy", 32'(busy), 32'd1);
    repeat (MULT_N) tick();
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd6, 32'hDEAD_BEEF, 32'd1);
    chk("rsvd_busy", 32'(busy), 32'd0);
    chk("rsvd_hi", hi, 32'hFFFF_FFFE);

    // reset in the middle of a mult
    issue(3'd0, 32'd7, 32'd9);
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    repeat (MULT_N + 3) tick();
    chk("rst_no_commit_lo", lo, 32'd0);

    // randomized traffic; start only when the model is idle
    repeat (1500) begin
      reset    = ($urandom % 200 == 0);
      d_md_use = 1'($urandom % 2);
      md_op    = 3'($urandom % 8);
      start    = (!m_busy && ($urandom % 3 == 0));
      e_v1     = pick();
      e_v2     = pick();
      tick();
    end
    start = 1'b0; reset = 1'b0;
    repeat (DIV_N + 2) tick();
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Consumes the operands and decoded operation delivered by the decode/execute pipeline register.
- Runs multi-cycle mult/div operations and holds the architectural HI/LO registers.
- Raises busy/stall so the hazard unit freezes decode while a conflicting instruction waits.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (>=1).
- DIV_CYCLES, 10, busy duration of div/divu in cycles (>=1).

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous active-high reset.
- start  input  1  issue strobe; E-stage instruction is an MDU op this cycle.
- md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo; 6-7 reserved.
- e_v1  input  32  rs operand (multiplicand, dividend, or mthi/mtlo source).
- e_v2  input  32  rt operand (multiplier or divisor).
- d_md_use  input  1  decode-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
- busy  output  1  multi-cycle operation in progress.
- stall  output  1  combinational: d_md_use & (busy | (start & md_op<=3)).
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset, synchronous: busy=0, hi=0, lo=0, counter=0, pending result=0. Reset mid-operation aborts the operation; HI/LO stay 0.
- Accept rule: start is accepted only at a posedge with reset=0 and busy=0.
- start while busy=1 is ignored. The hazard unit guarantees this never occurs; bench asserts it.
- mult/multu/div/divu accepted at edge k:
  - Full 64-bit result is computed from e_v1/e_v2 sampled at edge k and latched into pending_hi/pending_lo.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); busy=1 after edge k.
  - Counter decrements each edge. At the edge where counter==1, hi/lo take pending values, busy returns to 0, counter becomes 0.
  - busy is high for exactly N cycles; new hi/lo are visible after edge k+N.
- mult: signed 32x32->64 product, hi=[63:32], lo=[31:0]. multu: unsigned.
- div: lo=signed quotient truncated toward zero; hi=remainder with the dividend's sign.
- divu: unsigned quotient/remainder.
- Divide by zero: full busy duration still elapses; hi/lo keep their prior values.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo accepted at edge k: hi (resp. lo) = e_v1 after edge k. busy stays 0; no counter activity.
- Reserved md_op with start=1: no effect.
- No pipelining: one operation in flight at a time. A start in the cycle busy falls is legal and accepted.
- hi/lo are registered outputs. mfhi/mflo forwarding is handled outside this block.

Test Plan:
- Reset then idle -> hi=0, lo=0, busy=0 for all cycles; stall=0 even with d_md_use=1.
- start, mult, e_v1=0xFFFFFFFE (-2), e_v2=3 at edge 0 -> busy=1 for edges 1-5 (5 cycles); after edge 5 hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall=1 during busy when d_md_use=1.
- start, divu, 17/5 -> busy 10 cycles, then lo=3, hi=2. Repeat with div, 0xFFFFFFEF (-17)/5 -> lo=0xFFFFFFFD, hi=0xFFFFFFFE.
- mthi 0x12345678 then mtlo 0x9ABCDEF0 on consecutive edges -> hi/lo updated one edge each; busy never asserts.
- div by 0 with hi=0xAAAA, lo=0x5555 preloaded -> busy 10 cycles; hi/lo unchanged afterward. Back-to-back: multu 0xFFFFFFFF*0xFFFFFFFF started in the cycle busy drops -> accepted; hi=0xFFFFFFFE, lo=0x00000001.
- reset asserted at cycle 3 of a mult -> next edge busy=0, hi=lo=0; the aborted result never appears.
